// File: rtl/ascon_perm_ctrl.sv
// Round sequencer for the ASCON permutation: owns the 320-bit state and applies
// one round per clock, p^12 (rounds 0..11) or p^6 (rounds 6..11).
module ascon_perm_ctrl (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             mode_i,
   input  logic [0:4][63:0] state_i,
   output logic [0:4][63:0] state_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [3:0]       round_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t             fsm;
   logic [0:4][63:0] state_q;
   logic [3:0]       round_q;

   // single-round permutation p: pin = state register, round = counter
   logic [0:4][63:0] pin, pout;
   logic [63:0]      rc;
   logic [63:0]      a0, a1, a2, a3, a4;
   logic [63:0]      b0, b1, b2, b3, b4;
   logic [63:0]      c0, c1, c2, c3, c4;

   function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
      return (v >> n) | (v << (64 - n));
   endfunction

   assign pin = state_q;
   assign rc  = {56'd0, ~round_q, round_q};

   // constant addition folded into the S-box input layer
   assign a0 = pin[0] ^ pin[4];
   assign a1 = pin[1];
   assign a2 = pin[2] ^ rc ^ pin[1];
   assign a3 = pin[3];
   assign a4 = pin[4] ^ pin[3];

   assign b0 = a0 ^ (~a1 & a2);
   assign b1 = a1 ^ (~a2 & a3);
   assign b2 = a2 ^ (~a3 & a4);
   assign b3 = a3 ^ (~a4 & a0);
   assign b4 = a4 ^ (~a0 & a1);

   assign c0 = b0 ^ b4;
   assign c1 = b1 ^ b0;
   assign c2 = ~b2;
   assign c3 = b3 ^ b2;
   assign c4 = b4;

   assign pout[0] = c0 ^ ror(c0, 19) ^ ror(c0, 28);
   assign pout[1] = c1 ^ ror(c1, 61) ^ ror(c1, 39);
   assign pout[2] = c2 ^ ror(c2, 1)  ^ ror(c2, 6);
   assign pout[3] = c3 ^ ror(c3, 10) ^ ror(c3, 17);
   assign pout[4] = c4 ^ ror(c4, 7)  ^ ror(c4, 41);

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         fsm     <= IDLE;
         round_q <= '0;
         state_q <= '0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         case (fsm)
            IDLE, DONE: begin
               done_o <= 1'b0;
               if (start_i) begin
                  state_q <= state_i;
                  round_q <= mode_i ? 4'd6 : 4'd0;
                  fsm     <= RUN;
                  busy_o  <= 1'b1;
               end else begin
                  fsm    <= IDLE;
                  busy_o <= 1'b0;
               end
            end
            RUN: begin
               if (round_q > 4'd11) begin
                  fsm    <= IDLE;
                  busy_o <= 1'b0;
                  done_o <= 1'b0;
               end else begin
                  state_q <= pout;
                  if (round_q == 4'd11) begin
                     fsm    <= DONE;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                  end else begin
                     round_q <= round_q + 4'd1;
                  end
               end
            end
            default: begin
               fsm    <= IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b0;
            end
         endcase
      end
   end

   assign state_o = state_q;
   assign round_o = round_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed bench for ascon_perm_ctrl: checks timing of busy/done/round and the
// permutation result against a table-driven reference of the ASCON permutation.
module tb_ascon_perm_ctrl;

   typedef logic [0:4][63:0] st_t;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        start_i = 1'b0;
   logic        mode_i  = 1'b0;
   st_t         state_i = '0;
   st_t         state_o;
   logic        busy_o;
   logic        done_o;
   logic [3:0]  round_o;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   ascon_perm_ctrl dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .start_i (start_i),
      .mode_i  (mode_i),
      .state_i (state_i),
      .state_o (state_o),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .round_o (round_o)
   );

   always #5 clock_i = ~clock_i;

   function automatic logic [63:0] rot(input logic [63:0] v, input int unsigned n);
      logic [127:0] d;
      d = {v, v} >> n;
      return d[63:0];
   endfunction

   // reference permutation: rounds first..11, S-box applied column by column
   function automatic st_t golden(input st_t s_in, input int unsigned first);
      st_t        s;
      st_t        t;
      logic [4:0] col;
      logic [4:0] o;
      s = s_in;
      for (int unsigned r = first; r < 12; r++) begin
         s[2] = s[2] ^ 64'((15 - r) * 16 + r);
         for (int unsigned b = 0; b < 64; b++) begin
            col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
            o   = SBOX[col];
            t[0][b] = o[4];
            t[1][b] = o[3];
            t[2][b] = o[2];
            t[3][b] = o[1];
            t[4][b] = o[0];
         end
         s[0] = t[0] ^ rot(t[0], 19) ^ rot(t[0], 28);
         s[1] = t[1] ^ rot(t[1], 61) ^ rot(t[1], 39);
         s[2] = t[2] ^ rot(t[2], 1)  ^ rot(t[2], 6);
         s[3] = t[3] ^ rot(t[3], 10) ^ rot(t[3], 17);
         s[4] = t[4] ^ rot(t[4], 7)  ^ rot(t[4], 41);
      end
      return s;
   endfunction

   task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock_i);
      @(negedge clock_i);
   endtask

   // called just after the launch edge; returns in the DONE cycle
   task automatic expect_run(input string tag, input int unsigned first, input st_t exp);
      for (int unsigned k = first; k < 12; k++) begin
         check({tag, "_round"}, 320'(round_o), 320'(k));
         check({tag, "_busy"},  320'(busy_o),  320'(1));
         check({tag, "_nodone"}, 320'(done_o), 320'(0));
         step();
      end
      check({tag, "_done"},      320'(done_o),  320'(1));
      check({tag, "_busy_low"},  320'(busy_o),  320'(0));
      check({tag, "_round_end"}, 320'(round_o), 320'(11));
      check({tag, "_result"},    320'(state_o), 320'(exp));
   endtask

   st_t vec_a;
   st_t vec_b;

   initial begin
      vec_a = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
               64'h0011223344556677, 64'h8899aabbccddeeff};
      vec_b = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'hdeadbeefcafef00d,
               64'h5555aaaa3333cccc, 64'h0f0f0f0ff0f0f0f0};

      // reset values
      @(negedge clock_i);
      reset_i = 1'b1;
      step();
      step();
      check("rst_busy",  320'(busy_o),  320'(0));
      check("rst_done",  320'(done_o),  320'(0));
      check("rst_round", 320'(round_o), 320'(0));
      check("rst_state", 320'(state_o), 320'(0));
      reset_i = 1'b0;
      step();

      // p^12 known vector
      state_i = vec_a;
      mode_i  = 1'b0;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      state_i = '0;
      expect_run("p12", 0, golden(vec_a, 0));
      step();
      check("p12_done_pulse", 320'(done_o),  320'(0));
      check("p12_hold",       320'(state_o), 320'(golden(vec_a, 0)));

      // p^6 same vector
      state_i = vec_a;
      mode_i  = 1'b1;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      mode_i  = 1'b0;
      expect_run("p6", 6, golden(vec_a, 6));
      step();
      check("p6_done_pulse", 320'(done_o),  320'(0));
      check("p6_hold",       320'(state_o), 320'(golden(vec_a, 6)));

      // start held through a run: one done, then gapless relaunch with vec_b
      state_i = vec_a;
      start_i = 1'b1;
      step();
      state_i = vec_b;
      expect_run("hold", 0, golden(vec_a, 0));
      step();
      start_i = 1'b0;
      state_i = '0;
      expect_run("relaunch", 0, golden(vec_b, 0));
      step();
      check("relaunch_idle", 320'(busy_o), 320'(0));

      // reset mid-operation at round 5
      state_i = vec_b;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (round_o == 4'd5) break;
         step();
      end
      check("mid_reach5", 320'(round_o), 320'(5));
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      check("mid_busy",  320'(busy_o),  320'(0));
      check("mid_done",  320'(done_o),  320'(0));
      check("mid_state", 320'(state_o), 320'(0));
      check("mid_round", 320'(round_o), 320'(0));
      for (int i = 0; i < 10; i++) begin
         step();
         check("mid_no_done", 320'(done_o), 320'(0));
      end

      // reset/start collision
      state_i = vec_a;
      start_i = 1'b1;
      reset_i = 1'b1;
      step();
      start_i = 1'b0;
      reset_i = 1'b0;
      check("coll_busy",  320'(busy_o),  320'(0));
      check("coll_state", 320'(state_o), 320'(0));
      check("coll_round", 320'(round_o), 320'(0));
      step();
      check("coll_idle",  320'(busy_o),  320'(0));
      check("coll_done",  320'(done_o),  320'(0));
      check("coll_state2", 320'(state_o), 320'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
